cprv_fetch_unit: RTL and testbench
==================================

# cprv_fetch_unit

Instruction fetch stage sitting directly upstream of the single-port instruction memory wrapper (the valid/ready, 1-cycle-latency memory).
- Holds the PC and issues word read requests to the memory.
- Consumes the returned 64-bit words, selects the 32-bit instruction by `pc[2]`, and buffers instructions in a small FIFO for decode.
- Handles redirects by flushing the buffer and discarding the in-flight response.

## Interface
Parameters:
- `ADDR_WIDTH`, default 7: memory word address width; memory word = 64 bits.
- `XLEN`, default 64: PC width.
- `RESET_PC`, default 0: PC after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: instruction FIFO entries; must be ≥ 2.

Ports:
- `clk`  in  1: clock, all state on rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `redirect_i`  in  1: load new PC, flush.
- `redirect_pc_i`  in  XLEN: target PC; bits [1:0] forced to 0 internally.
- `mem_valid_o`  out  1: read request valid (to memory `valid_i`).
- `mem_ready_i`  in  1: memory accepts request (from memory `ready_o`).
- `mem_addr_o`  out  ADDR_WIDTH: word address = `pc[ADDR_WIDTH+2:3]`.
- `mem_valid_i`  in  1: read data valid (from memory `valid_o`).
- `mem_ready_o`  out  1: response accept (to memory `ready_i`); constant 1.
- `mem_rdata_i`  in  64: read data.
- `inst_valid_o`  out  1: instruction valid to decode.
- `inst_ready_i`  in  1: decode accepts.
- `inst_o`  out  32: instruction.
- `inst_pc_o`  out  XLEN: PC of `inst_o`.

## Operation
- State:
  - `pc`.
  - In-flight register: `inflight`, `inflight_pc`, `inflight_kill`.
  - FIFO of {instruction, pc}, `DEPTH` entries, with count/pointers.
- `pop` = `inst_valid_o & inst_ready_i`; `inst_valid_o` = count != 0; outputs are the FIFO head.
- Issue condition: `mem_valid_o` = `!redirect_i && (count - pop + inflight_live) < DEPTH`.
  - `inflight_live` = `inflight & !inflight_kill`.
  - A slot freed by a same-cycle pop is reusable.
- Request accepted (`mem_valid_o & mem_ready_i`):
  - `inflight`←1, `inflight_pc`←`pc`, `inflight_kill`←0, `pc`←`pc+4` (wraps mod 2^XLEN).
- Response (`mem_valid_i & inflight`):
  - `inflight`←0 unless a new request is accepted the same cycle.
  - If not killed, push {`inflight_pc[2]` ? `rdata[63:32]` : `rdata[31:0]`, `inflight_pc`}.
- `mem_valid_i` while `inflight`=0 (stale memory valid after reset) is ignored.
- `mem_addr_o` must not change in any cycle following one where `mem_ready_i`=0, because memory read data tracks the address. `pc` only advances on acceptance, which guarantees this.
- Redirect (highest priority):
  - `pc`←`{redirect_pc_i[XLEN-1:2],2'b00}`.
  - FIFO count←0; `inflight_kill`←1 if `inflight`; no request this cycle.
  - A pop in the same cycle is still a completed transfer; every other entry is discarded.
  - A response arriving in the redirect cycle is discarded.
- FIFO full: no push occurs, because credits guarantee space. Push and pop in the same cycle at full or empty are both legal.

## Timing
- Reset values: `pc`=`RESET_PC`, count=0, `inflight`=0, `inflight_kill`=0, `inst_valid_o`=0, `inst_o`=0, `inst_pc_o`=0.
  - `mem_valid_o`=1 (combinational) with `mem_addr_o`=`RESET_PC[ADDR_WIDTH+2:3]`.
- Latency: request accepted in cycle N → `mem_valid_i` in N+1 → `inst_valid_o` in N+2.
- Redirect in cycle R:
  - first new request in R+1;
  - first new instruction valid in R+3;
  - `inst_valid_o`=0 in R+1 and R+2.
- Throughput: 1 instruction/cycle sustained when `inst_ready_i`=1 and `mem_ready_i`=1.
- Reset mid-operation: all state cleared asynchronously; outstanding response dropped.

## Test plan
- Reset `RESET_PC`=0x0, memory word0=0x22221111_00000013, word1=0x44443333_00100093, `inst_ready_i`=1 → instructions 0x00000013@0, 0x22221111@4, 0x00100093@8, 0x44443333@0xC. First valid 2 cycles after the first acceptance, then one per cycle.
- Hold `inst_ready_i`=0 from the start → FIFO fills to DEPTH. After that `mem_valid_o`=0, and `mem_addr_o` is stable for the whole stall. Release → no drop or duplicate, order preserved.
- Redirect to 0x40 while the FIFO holds 2 entries and one response is in flight → those entries and the response are discarded. Next instruction has `inst_pc_o`=0x40, valid exactly 3 cycles after the redirect.
- Redirect with `redirect_pc_i`=0x43 → `inst_pc_o`=0x40, and the instruction is taken from the lower half of word 8.
- Toggle `mem_ready_i` randomly and `inst_ready_i` randomly for 1000 cycles → instruction stream equals sequential memory contents, with no gaps in PC.
- Assert `rst_n`=0 while a request is in flight, with a stale `mem_valid_i`=1 after release → stale data ignored, stream restarts at `RESET_PC`.

Source files
------------

// File: rtl/cprv_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a 1-cycle-latency memory,
// selects the 32-bit half by pc[2] and buffers {inst, pc} in a small FIFO for decode.
module cprv_fetch_unit #(
    parameter int unsigned     ADDR_WIDTH = 7,
    parameter int unsigned     XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_i,
    input  logic [XLEN-1:0]       redirect_pc_i,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [63:0]           mem_rdata_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [31:0]           inst_o,
    output logic [XLEN-1:0]       inst_pc_o
);

    localparam int unsigned       PTR_W    = $clog2(DEPTH);
    localparam int unsigned       CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

    logic [XLEN-1:0]  r_pc;
    logic             r_inflight;
    logic [XLEN-1:0]  r_inflight_pc;
    logic             r_inflight_kill;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [31:0]      r_inst_mem [DEPTH];
    logic [XLEN-1:0]  r_pc_mem   [DEPTH];

    logic             w_pop;
    logic             w_live;
    logic [CNT_W:0]   w_credit;
    logic             w_accept;
    logic             w_resp;
    logic             w_push;
    logic [31:0]      w_sel_inst;

    logic [XLEN-1:0]  w_pc_next;
    logic             w_inflight_next;
    logic [XLEN-1:0]  w_inflight_pc_next;
    logic             w_kill_next;
    logic [CNT_W-1:0] w_count_next;
    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;

    assign inst_valid_o = (r_count != '0);
    assign inst_o       = r_inst_mem[r_rd_ptr];
    assign inst_pc_o    = r_pc_mem[r_rd_ptr];
    assign w_pop        = inst_valid_o & inst_ready_i;
    assign w_live       = r_inflight & ~r_inflight_kill;

    // Credits: entries held + live response, counting a same-cycle pop as already free.
    assign w_credit = {1'b0, r_count} - {{CNT_W{1'b0}}, w_pop} + {{CNT_W{1'b0}}, w_live};

    assign mem_valid_o = ~redirect_i & (w_credit < DEPTH_C);
    assign mem_addr_o  = r_pc[ADDR_WIDTH+2:3];
    assign mem_ready_o = 1'b1;
    assign w_accept    = mem_valid_o & mem_ready_i;
    assign w_resp      = mem_valid_i & r_inflight;
    assign w_push      = w_resp & ~r_inflight_kill & ~redirect_i;
    assign w_sel_inst  = r_inflight_pc[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];

    always_comb begin
        w_pc_next          = r_pc;
        w_inflight_next    = r_inflight;
        w_inflight_pc_next = r_inflight_pc;
        w_kill_next        = r_inflight_kill;
        w_count_next       = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_wr_ptr_next      = r_wr_ptr;
        w_rd_ptr_next      = r_rd_ptr;

        if (w_accept) begin
            w_pc_next          = r_pc + XLEN'(4);
            w_inflight_next    = 1'b1;
            w_inflight_pc_next = r_pc;
            w_kill_next        = 1'b0;
        end else if (w_resp) begin
            w_inflight_next = 1'b0;
        end

        if (w_push) begin
            w_wr_ptr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
        end

        if (redirect_i) begin
            w_pc_next     = redirect_pc_i & ~XLEN'(3);
            w_count_next  = '0;
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            if (r_inflight) begin
                w_kill_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= RESET_PC;
            r_inflight      <= 1'b0;
            r_inflight_pc   <= '0;
            r_inflight_kill <= 1'b0;
            r_count         <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
        end else begin
            r_pc            <= w_pc_next;
            r_inflight      <= w_inflight_next;
            r_inflight_pc   <= w_inflight_pc_next;
            r_inflight_kill <= w_kill_next;
            r_count         <= w_count_next;
            r_wr_ptr        <= w_wr_ptr_next;
            r_rd_ptr        <= w_rd_ptr_next;
        end
    end

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_inst_mem[i] <= '0;
                r_pc_mem[i]   <= '0;
            end
        end else if (w_push) begin
            r_inst_mem[r_wr_ptr] <= w_sel_inst;
            r_pc_mem[r_wr_ptr]   <= r_inflight_pc;
        end
    end

endmodule

// File: tb/tb_cprv_fetch_unit.sv
// Bench for cprv_fetch_unit: 1-cycle memory model, in-order stream scoreboard and
// directed checks for reset, latency, stall, redirect, random handshakes and mid-run reset.
module tb_cprv_fetch_unit;

    localparam int unsigned AW    = 7;
    localparam int unsigned XL    = 64;
    localparam int unsigned DEPTH = 3;

    logic          clk           = 1'b0;
    logic          rst_n         = 1'b0;
    logic          redirect_i    = 1'b0;
    logic [XL-1:0] redirect_pc_i = '0;
    logic          mem_ready_i   = 1'b1;
    logic          inst_ready_i  = 1'b1;
    logic          stale_force   = 1'b0;

    logic          mem_valid_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_ready_o;
    logic          mem_valid_i;
    logic [63:0]   mem_rdata_i;
    logic          inst_valid_o;
    logic [31:0]   inst_o;
    logic [XL-1:0] inst_pc_o;

    logic          r_resp_v = 1'b0;
    logic [63:0]   r_rdata  = '0;
    logic [63:0]   mem [128];

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    cprv_fetch_unit #(
        .ADDR_WIDTH (AW),
        .XLEN       (XL),
        .RESET_PC   ('0),
        .DEPTH      (DEPTH)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_valid_o   (mem_valid_o),
        .mem_ready_i   (mem_ready_i),
        .mem_addr_o    (mem_addr_o),
        .mem_valid_i   (mem_valid_i),
        .mem_ready_o   (mem_ready_o),
        .mem_rdata_i   (mem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word_of(input int k);
        logic [31:0] lo;
        if (k == 0) return 64'h22221111_00000013;
        if (k == 1) return 64'h44443333_00100093;
        lo = 32'hC0DE0000 | 32'(k * 8);
        return {lo + 32'd4, lo};
    endfunction

    // Reference: the instruction at byte address p is the p[2] half of word p[9:3].
    function automatic logic [31:0] inst_at(input logic [63:0] p);
        logic [63:0] w;
        w = word_of(int'(p[9:3]));
        return p[2] ? w[63:32] : w[31:0];
    endfunction

    initial begin
        for (int k = 0; k < 128; k++) mem[k] = word_of(k);
    end

    // Memory with one cycle of latency; not reset, so it can present a stale valid.
    always @(posedge clk) begin
        r_resp_v <= mem_valid_o & mem_ready_i;
        r_rdata  <= mem[mem_addr_o];
    end
    assign mem_valid_i = r_resp_v | stale_force;
    assign mem_rdata_i = stale_force ? 64'hBAD0BAD0_BAD0BAD0 : r_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream scoreboard: every transfer must carry the next sequential PC and its word.
    logic [63:0] exp_pc    = '0;
    logic        prev_hold = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc    = '0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) check("addr_stable", 64'(mem_addr_o), 64'(prev_addr));
            if (inst_valid_o && inst_ready_i) begin
                check("stream_pc", inst_pc_o, exp_pc);
                check("stream_inst", 64'(inst_o), 64'(inst_at(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                n_pops++;
            end
            if (redirect_i) begin
                check("no_req_on_redirect", 64'(mem_valid_o), 64'd0);
                exp_pc = redirect_pc_i & ~64'd3;
            end
            prev_hold = !mem_ready_i && !redirect_i;
            prev_addr = mem_addr_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [63:0] t1_pc   [4] = '{64'h0, 64'h4, 64'h8, 64'hC};
    logic [31:0] t1_inst [4] = '{32'h00000013, 32'h22221111, 32'h00100093, 32'h44443333};

    initial begin
        int pops_start;

        // Reset state
        tick();
        check("rst_inst_valid", 64'(inst_valid_o), 64'd0);
        check("rst_inst", 64'(inst_o), 64'd0);
        check("rst_inst_pc", inst_pc_o, 64'd0);
        check("rst_mem_valid", 64'(mem_valid_o), 64'd1);
        check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        check("rst_mem_ready", 64'(mem_ready_o), 64'd1);

        // Sequential fetch, first valid two cycles after first acceptance
        tick();
        rst_n = 1'b1;
        mid();
        check("t1_c0_valid", 64'(inst_valid_o), 64'd0);
        tick(); mid();
        check("t1_c1_valid", 64'(inst_valid_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick(); mid();
            check("t1_valid", 64'(inst_valid_o), 64'd1);
            check("t1_pc", inst_pc_o, t1_pc[i]);
            check("t1_inst", 64'(inst_o), 64'(t1_inst[i]));
        end
        repeat (10) tick();

        // Stall: FIFO fills, requests stop, address holds
        rst_n = 1'b0;
        tick();
        inst_ready_i = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            mid();
            if (c == 3 || c == 7) begin
                check("t2_mem_valid", 64'(mem_valid_o), 64'd0);
                check("t2_mem_addr", 64'(mem_addr_o), 64'd1);
                check("t2_head_pc", inst_pc_o, 64'd0);
            end
        end
        tick();
        inst_ready_i = 1'b1;
        repeat (12) tick();

        // Redirect with two buffered entries and a live response
        rst_n = 1'b0;
        tick();
        inst_ready_i = 1'b0;
        rst_n = 1'b1;
        tick(); tick(); tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h40;
        mid();
        check("t3_fifo_busy", 64'(inst_valid_o), 64'd1);
        check("t3_resp_live", 64'(mem_valid_i), 64'd1);
        tick();
        redirect_i   = 1'b0;
        inst_ready_i = 1'b1;
        mid();
        check("t3_r1_valid", 64'(inst_valid_o), 64'd0);
        check("t3_r1_req", 64'(mem_valid_o), 64'd1);
        check("t3_r1_addr", 64'(mem_addr_o), 64'd8);
        tick(); mid();
        check("t3_r2_valid", 64'(inst_valid_o), 64'd0);
        tick(); mid();
        check("t3_r3_valid", 64'(inst_valid_o), 64'd1);
        check("t3_r3_pc", inst_pc_o, 64'h40);
        check("t3_r3_inst", 64'(inst_o), 64'hC0DE0040);
        repeat (6) tick();

        // Unaligned redirect target is forced to word alignment
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h43;
        mid();
        tick();
        redirect_i = 1'b0;
        mid();
        check("t4_r1_valid", 64'(inst_valid_o), 64'd0);
        tick(); mid();
        check("t4_r2_valid", 64'(inst_valid_o), 64'd0);
        tick(); mid();
        check("t4_r3_valid", 64'(inst_valid_o), 64'd1);
        check("t4_r3_pc", inst_pc_o, 64'h40);
        check("t4_r3_inst", 64'(inst_o), 64'hC0DE0040);

        // Random handshakes with occasional redirects
        pops_start = n_pops;
        for (int c = 0; c < 1000; c++) begin
            tick();
            mem_ready_i   = 1'($urandom_range(0, 1));
            inst_ready_i  = 1'($urandom_range(0, 1));
            redirect_i    = ($urandom_range(0, 49) == 0);
            redirect_pc_i = 64'($urandom_range(0, 1023));
        end
        tick();
        redirect_i   = 1'b0;
        mem_ready_i  = 1'b1;
        inst_ready_i = 1'b1;
        check("t5_progress", 64'(n_pops - pops_start >= 150), 64'd1);
        repeat (8) tick();

        // Reset while a request is in flight, then a stale memory valid
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(inst_valid_o), 64'd0);
        check("t6_rst_pc", inst_pc_o, 64'd0);
        check("t6_rst_addr", 64'(mem_addr_o), 64'd0);
        tick(); tick();
        rst_n       = 1'b1;
        stale_force = 1'b1;
        mid();
        check("t6_c0_valid", 64'(inst_valid_o), 64'd0);
        tick();
        stale_force = 1'b0;
        mid();
        check("t6_c1_valid", 64'(inst_valid_o), 64'd0);
        tick(); mid();
        check("t6_c2_valid", 64'(inst_valid_o), 64'd1);
        check("t6_c2_pc", inst_pc_o, 64'd0);
        check("t6_c2_inst", 64'(inst_o), 64'h13);
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
